tag_capture_ctrl: RTL and testbench
===================================

Name: tag_capture_ctrl

Overview:
- Sequencer for the time-tag buffer: NM single-port memory banks, each 2^N words of B bits.
- In capture, writes incoming tags into the banks in the same interleaved word order the readout engine consumes: bank index is the fast index, address the slow index.
- After capture, asserts the readout start level, watches the readout AXIS stream for the final beat, then releases the start level.
- Sits between the tag source, the bank write ports and the readout engine; status is exported to the register block.

Parameters:
- NM, 8, number of memory banks (power of 2, ≥2).
- N, 8, bank address width.
- B, 8, tag/data width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  tag input valid.
- s_axis_tready  out  1  tag input ready.
- s_axis_tdata  in  B  tag value.
- mem_we  out  NM  one-hot bank write enable.
- mem_addr  out  N  write address, common to all banks.
- mem_di  out  B  write data, common to all banks.
- rd_start  out  1  start level to the readout engine.
- rd_tvalid  in  1  readout stream valid (monitor only).
- rd_tready  in  1  readout stream ready (monitor only).
- rd_tlast  in  1  readout stream last (monitor only).
- ARM_REG  in  1  capture arm level, quasi-static, foreign domain.
- STOP_REG  in  1  early-stop request, quasi-static, foreign domain.
- CNT_REG  out  N+log2(NM)+1  tags written in the current/last capture.
- FULL_REG  out  1  capture ended on full.
- BUSY_REG  out  1  high in any state except IDLE.

Behaviour:
- ARM_REG and STOP_REG each pass through a synchronizer_n instance before use.
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; bank counter, address counter and tag count cleared.
- States: IDLE, CAPTURE, READOUT, DONE.
- IDLE:
  - On ARM_resync=1, go to CAPTURE.
  - On that transition, clear bank counter, address counter, CNT and FULL.
- CAPTURE:
  - s_axis_tready=1 while CAPTURE and not full.
  - Each accepted beat (tvalid & tready) drives, in the same cycle:
    - mem_we = one-hot(bank counter);
    - mem_addr = address counter;
    - mem_di = tdata.
  - The write is combinational from the handshake; zero latency.
  - Next cycle: bank counter +1; on bank wrap (== NM-1), address counter +1; CNT +1.
  - Full = CNT == NM·2^N. When the last slot is written, set FULL, deassert tready next cycle, go to READOUT.
  - STOP_resync=1 goes to READOUT without setting FULL. A beat accepted in that same cycle is still written and counted.
  - Simultaneous full and STOP: FULL=1.
  - ARM_resync dropping to 0 in CAPTURE behaves as STOP.
- READOUT:
  - rd_start=1, s_axis_tready=0, mem_we=0.
  - The readout engine always reads the full buffer, NM·2^N beats. Unwritten slots hold stale data; software uses CNT.
  - Exit condition: a cycle with rd_tvalid & rd_tready & rd_tlast goes to DONE.
  - rd_tlast without a handshake is ignored.
- DONE:
  - rd_start=0; CNT and FULL held.
  - On ARM_resync=0, go to IDLE.
  - A new capture requires an ARM 0→1 cycle.
- Async reset at any point returns to IDLE with all outputs 0 within the reset assertion.
  - rd_start then drops, which resets the readout engine to its idle state.
- Counter widths: bank counter log2(NM), address counter N; both wrap naturally. CNT does not wrap; max value NM·2^N.
- mem_we is never asserted outside CAPTURE.
- BUSY_REG = (state != IDLE), registered.

Decomposition:
- Shared package tag_pkg holds:
  - state_t enum (IDLE, CAPTURE, READOUT, DONE);
  - localparams NM_LOG2 = $clog2(NM) and DEPTH = NM·2^N as functions/macros of NM and N.
- Reuse the existing synchronizer_n for ARM and STOP.
- One natural sub-module: tag_write_addr_gen, holding the bank/address/count counters with clear, increment and full outputs. The FSM stays in the top.

Test Plan (NM=4, N=2, B=8, depth 16):
- Arm and stream 16 tags 0x00..0x0F with tvalid always 1:
  - tag k writes bank k%4, addr k/4, with mem_we one-hot;
  - tready drops after the 16th beat; FULL=1, CNT=16, rd_start=1.
- After the previous test, drive 16 readout beats, tlast on the 16th with tready toggling 1,0,1:
  - rd_start falls one cycle after the tlast handshake; state DONE;
  - ARM=0 → IDLE, BUSY=0.
- Arm, send 5 tags, pulse STOP:
  - CNT=5, FULL=0, READOUT entered, no further mem_we even with tvalid held high.
- During READOUT, assert rd_tlast with rd_tvalid=0 for 3 cycles:
  - remains in READOUT; rd_start stays 1.
- Assert aresetn=0 asynchronously mid-CAPTURE after 7 tags:
  - all outputs 0 immediately; after release, IDLE.
  - Re-arm starts at bank 0, addr 0, CNT=0.
- Keep ARM=1 through DONE:
  - no recapture.
  - ARM 1→0→1 starts a new capture with CNT cleared.

Source files
------------

// File: rtl/tag_pkg.sv
// Shared types and sizing helpers for the time-tag capture sequencer.
package tag_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int calc_nm_log2(input int nm);
    return $clog2(nm);
  endfunction

  function automatic int calc_depth(input int nm, input int n);
    return nm * (2 ** n);
  endfunction

endpackage

// File: rtl/synchronizer_n.sv
// Multi-stage flop synchronizer for quasi-static levels from a foreign domain.
module synchronizer_n #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/tag_write_addr_gen.sv
// Bank/address/count counters: bank is the fast index, address the slow one.
module tag_write_addr_gen
  import tag_pkg::*;
#(
  parameter int NM = 8,
  parameter int N  = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        i_clr,
  input  logic                        i_inc,
  output logic [$clog2(NM)-1:0]       o_bank,
  output logic [N-1:0]                o_addr,
  output logic [N+$clog2(NM):0]       o_cnt,
  output logic                        o_last,
  output logic                        o_full
);

  localparam int NM_LOG2 = calc_nm_log2(NM);
  localparam int CW      = N + NM_LOG2 + 1;
  localparam logic [CW-1:0]      DEPTH_C  = CW'(calc_depth(NM, N));
  localparam logic [NM_LOG2-1:0] BANK_MAX = NM_LOG2'(NM - 1);

  logic [NM_LOG2-1:0] r_bank;
  logic [N-1:0]       r_addr;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bank <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_bank <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_inc) begin
      r_bank <= r_bank + 1'b1;
      if (r_bank == BANK_MAX) begin
        r_addr <= r_addr + 1'b1;
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bank = r_bank;
  assign o_addr = r_addr;
  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == DEPTH_C - 1'b1);
  assign o_full = (r_cnt == DEPTH_C);

endmodule

// File: rtl/tag_capture_ctrl.sv
// Capture sequencer: interleaved tag writes into NM banks, then readout hand-off.
module tag_capture_ctrl
  import tag_pkg::*;
#(
  parameter int NM = 8,
  parameter int N  = 8,
  parameter int B  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [B-1:0]          s_axis_tdata,
  output logic [NM-1:0]         mem_we,
  output logic [N-1:0]          mem_addr,
  output logic [B-1:0]          mem_di,
  output logic                  rd_start,
  input  logic                  rd_tvalid,
  input  logic                  rd_tready,
  input  logic                  rd_tlast,
  input  logic                  ARM_REG,
  input  logic                  STOP_REG,
  output logic [N+$clog2(NM):0] CNT_REG,
  output logic                  FULL_REG,
  output logic                  BUSY_REG
);

  localparam int NM_LOG2 = calc_nm_log2(NM);

  state_t             r_state;
  logic               r_rd_start;
  logic               r_full;
  logic               r_busy;

  logic               w_arm;
  logic               w_stop;
  logic               w_accept;
  logic               w_clr;
  logic               w_last;
  logic               w_full;
  logic [NM_LOG2-1:0] w_bank;
  logic [N-1:0]       w_addr;
  logic [NM-1:0]      w_onehot;

  synchronizer_n #(.STAGES(2), .WIDTH(1)) u_sync_arm (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_d     (ARM_REG),
    .o_q     (w_arm)
  );

  synchronizer_n #(.STAGES(2), .WIDTH(1)) u_sync_stop (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_d     (STOP_REG),
    .o_q     (w_stop)
  );

  assign w_clr    = (r_state == IDLE) & w_arm;
  assign s_axis_tready = (r_state == CAPTURE) & ~w_full;
  assign w_accept = s_axis_tvalid & s_axis_tready;

  tag_write_addr_gen #(.NM(NM), .N(N)) u_addr_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_clr   (w_clr),
    .i_inc   (w_accept),
    .o_bank  (w_bank),
    .o_addr  (w_addr),
    .o_cnt   (CNT_REG),
    .o_last  (w_last),
    .o_full  (w_full)
  );

  always_comb begin
    w_onehot         = '0;
    w_onehot[w_bank] = 1'b1;
  end

  // Write port is gated by the handshake so nothing toggles outside a beat.
  assign mem_we   = w_accept ? w_onehot     : '0;
  assign mem_addr = w_accept ? w_addr       : '0;
  assign mem_di   = w_accept ? s_axis_tdata : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_rd_start <= 1'b0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arm) begin
            r_state <= CAPTURE;
            r_full  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          // Filling the last slot wins over a concurrent stop, so FULL is set.
          if (w_accept & w_last) begin
            r_state    <= READOUT;
            r_full     <= 1'b1;
            r_rd_start <= 1'b1;
          end else if (w_stop | ~w_arm) begin
            r_state    <= READOUT;
            r_rd_start <= 1'b1;
          end
        end
        READOUT: begin
          if (rd_tvalid & rd_tready & rd_tlast) begin
            r_state    <= DONE;
            r_rd_start <= 1'b0;
          end
        end
        DONE: begin
          if (!w_arm) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rd_start <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_start = r_rd_start;
  assign FULL_REG = r_full;
  assign BUSY_REG = r_busy;

endmodule

// File: tb/tb_tag_capture_ctrl.sv
// Directed bench for tag_capture_ctrl with NM=4, N=2, B=8 (depth 16).
module tb_tag_capture_ctrl;

  localparam int NM = 4;
  localparam int N  = 2;
  localparam int B  = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [B-1:0]  s_axis_tdata;
  logic [NM-1:0] mem_we;
  logic [N-1:0]  mem_addr;
  logic [B-1:0]  mem_di;
  logic          rd_start;
  logic          rd_tvalid;
  logic          rd_tready;
  logic          rd_tlast;
  logic          ARM_REG;
  logic          STOP_REG;
  logic [N+2:0]  CNT_REG;
  logic          FULL_REG;
  logic          BUSY_REG;

  int n_chk  = 0;
  int n_fail = 0;

  tag_capture_ctrl #(.NM(NM), .N(N), .B(B)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_di        (mem_di),
    .rd_start      (rd_start),
    .rd_tvalid     (rd_tvalid),
    .rd_tready     (rd_tready),
    .rd_tlast      (rd_tlast),
    .ARM_REG       (ARM_REG),
    .STOP_REG      (STOP_REG),
    .CNT_REG       (CNT_REG),
    .FULL_REG      (FULL_REG),
    .BUSY_REG      (BUSY_REG)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tready(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_rd_start(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (rd_start) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!BUSY_REG) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Single readout beat with tlast, handshaken on the next edge.
  task automatic last_beat();
    @(posedge aclk); #1;
    rd_tvalid = 1'b1; rd_tready = 1'b1; rd_tlast = 1'b1;
    @(posedge aclk); #1;
    rd_tvalid = 1'b0; rd_tready = 1'b0; rd_tlast = 1'b0;
  endtask

  initial begin
    int   beat;
    logic done;

    aresetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    rd_tvalid = 1'b0; rd_tready = 1'b0; rd_tlast = 1'b0;
    ARM_REG = 1'b0; STOP_REG = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_busy", 32'(BUSY_REG), 0);
    chk("rst_rd_start", 32'(rd_start), 0);
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_cnt", 32'(CNT_REG), 0);
    #5 aresetn = 1'b1;

    // Fill the whole buffer with tvalid held high.
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h00; ARM_REG = 1'b1;
    wait_tready("t1_tready_up");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t1_we%0d", k), 32'(mem_we), 32'(1 << (k % 4)));
      chk($sformatf("t1_addr%0d", k), 32'(mem_addr), 32'(k / 4));
      chk($sformatf("t1_di%0d", k), 32'(mem_di), 32'(k));
      @(posedge aclk); #1;
      s_axis_tdata = 8'(k + 1);
      @(negedge aclk);
    end
    chk("t1_tready_down", 32'(s_axis_tready), 0);
    chk("t1_we_off", 32'(mem_we), 0);
    chk("t1_full", 32'(FULL_REG), 1);
    chk("t1_cnt", 32'(CNT_REG), 16);
    chk("t1_rd_start", 32'(rd_start), 1);
    s_axis_tvalid = 1'b0;

    // 16 readout beats, tready toggling; tlast first appears without handshake.
    beat = 0;
    done = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge aclk); #1;
      rd_tvalid = 1'b1;
      rd_tready = (cyc % 2 == 0);
      rd_tlast  = (beat == 15);
      @(negedge aclk);
      if (rd_tlast && !rd_tready) chk("t2_tlast_nohs", 32'(rd_start), 1);
      if (rd_tready) begin
        if (rd_tlast) begin
          chk("t2_rd_start_at_hs", 32'(rd_start), 1);
          done = 1'b1;
          break;
        end
        beat++;
      end
    end
    chk("t2_done_seen", 32'(done), 1);
    chk("t2_beats", 32'(beat), 15);
    @(posedge aclk); #1;
    rd_tvalid = 1'b0; rd_tready = 1'b0; rd_tlast = 1'b0;
    @(negedge aclk);
    chk("t2_rd_start_fall", 32'(rd_start), 0);
    chk("t2_busy_done", 32'(BUSY_REG), 1);
    chk("t2_full_held", 32'(FULL_REG), 1);
    ARM_REG = 1'b0;
    wait_idle("t2_idle");

    // Early stop after five tags.
    ARM_REG = 1'b1;
    wait_tready("t3_tready_up");
    chk("t3_full_clr", 32'(FULL_REG), 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("t3_we%0d", k), 32'(mem_we), 32'(1 << (k % 4)));
      chk($sformatf("t3_addr%0d", k), 32'(mem_addr), 32'(k / 4));
      @(posedge aclk); #1;
      if (k == 4) s_axis_tvalid = 1'b0;
      else s_axis_tdata = s_axis_tdata + 8'd1;
    end
    STOP_REG = 1'b1;
    wait_rd_start("t3_readout");
    STOP_REG = 1'b0;
    chk("t3_cnt", 32'(CNT_REG), 5);
    chk("t3_full", 32'(FULL_REG), 0);
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("t3_no_we", 32'(mem_we), 0);
      chk("t3_no_tready", 32'(s_axis_tready), 0);
    end
    s_axis_tvalid = 1'b0;

    // tlast without tvalid must not end readout.
    @(posedge aclk); #1;
    rd_tvalid = 1'b0; rd_tready = 1'b1; rd_tlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("t4_rd_start_hold", 32'(rd_start), 1);
    end
    @(posedge aclk); #1;
    rd_tready = 1'b0; rd_tlast = 1'b0;
    last_beat();
    @(negedge aclk);
    chk("t4_rd_start_fall", 32'(rd_start), 0);
    chk("t4_cnt_held", 32'(CNT_REG), 5);
    ARM_REG = 1'b0;
    wait_idle("t4_idle");

    // Asynchronous reset mid-capture after seven tags.
    ARM_REG = 1'b1;
    wait_tready("t5_tready_up");
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h40;
    repeat (7) @(posedge aclk);
    #2;
    chk("t5_cnt_pre", 32'(CNT_REG), 7);
    #1;
    aresetn = 1'b0; ARM_REG = 1'b0;
    #1;
    chk("t5_rst_we", 32'(mem_we), 0);
    chk("t5_rst_addr", 32'(mem_addr), 0);
    chk("t5_rst_di", 32'(mem_di), 0);
    chk("t5_rst_tready", 32'(s_axis_tready), 0);
    chk("t5_rst_cnt", 32'(CNT_REG), 0);
    chk("t5_rst_busy", 32'(BUSY_REG), 0);
    chk("t5_rst_rd_start", 32'(rd_start), 0);
    chk("t5_rst_full", 32'(FULL_REG), 0);
    #20 aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t5_idle_busy", 32'(BUSY_REG), 0);
    ARM_REG = 1'b1;
    wait_tready("t5_rearm");
    chk("t5_rearm_cnt", 32'(CNT_REG), 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55;
    @(negedge aclk);
    chk("t5_rearm_we", 32'(mem_we), 1);
    chk("t5_rearm_addr", 32'(mem_addr), 0);
    chk("t5_rearm_di", 32'(mem_di), 32'h55);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("t5_rearm_cnt1", 32'(CNT_REG), 1);

    // ARM held through DONE: no recapture until ARM cycles low.
    STOP_REG = 1'b1;
    wait_rd_start("t6_readout");
    STOP_REG = 1'b0;
    last_beat();
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      chk("t6_hold_busy", 32'(BUSY_REG), 1);
      chk("t6_hold_tready", 32'(s_axis_tready), 0);
    end
    chk("t6_hold_cnt", 32'(CNT_REG), 1);
    chk("t6_hold_rd_start", 32'(rd_start), 0);
    ARM_REG = 1'b0;
    wait_idle("t6_idle");
    ARM_REG = 1'b1;
    wait_tready("t6_recapture");
    chk("t6_cnt_clr", 32'(CNT_REG), 0);
    chk("t6_full_clr", 32'(FULL_REG), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
